// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM states, field limits,
// field indexing and small helpers used by the top and its datapath.
package countdown_timer_pkg;

  // Timer control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Largest value each displayed field may hold
  localparam logic [7:0] MAX_SECONDS = 8'd59;
  localparam logic [7:0] MAX_MINUTES = 8'd59;
  localparam logic [7:0] MAX_HOURS   = 8'd99;

  // Time is held as a small array of fields, least significant first,
  // so the borrow chain can be built with a generate loop.
  localparam int NUM_FIELDS = 3;
  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HR   = 2;

  // Upper limit of a field given its index
  function automatic logic [7:0] field_max(input int idx);
    logic [7:0] limit;
    case (idx)
      FIELD_SEC: limit = MAX_SECONDS;
      FIELD_MIN: limit = MAX_MINUTES;
      default:   limit = MAX_HOURS;
    endcase
    return limit;
  endfunction

  // Saturate a loaded field to its limit
  function automatic logic [7:0] clamp_field(input logic [7:0] value,
                                             input logic [7:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and display bundle of the countdown timer. The master side
// issues load/start/pause pulses; the slave side is the timer itself.
interface countdown_timer_if;

  logic       load;
  logic [7:0] load_h;
  logic [7:0] load_m;
  logic [7:0] load_s;
  logic       start;
  logic       pause;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output load, load_h, load_m, load_s, start, pause,
    input  hours, minutes, seconds, running, expired, done
  );

  modport slave (
    input  load, load_h, load_m, load_s, start, pause,
    output hours, minutes, seconds, running, expired, done
  );

endinterface

// File: rtl/countdown_timer_sec_tick_gen.sv
// One-second prescaler: counts enabled clock cycles 0..TICKS_PER_SEC-1 and
// raises tick for the single cycle on which the count wraps back to zero.
// The count freezes while enable is low, so a paused countdown resumes
// mid-second where it left off.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50000000  // must be at least 2
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count_reg;
  logic             at_last;

  assign at_last = (count_reg == LAST_COUNT);

  // A clear in the same cycle as a wrap discards the wrap, so no tick.
  assign tick = enable && at_last && !clear;

  // Prescaler count: clear wins, otherwise advance and wrap while enabled
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= at_last ? '0 : count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with load/start/pause control. Remaining time is
// held as three binary fields that drive the display outputs directly; a
// prescaler sub-module paces the decrements at one per TICKS_PER_SEC cycles.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000  // must be at least 2
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  countdown_timer_if.slave   bus
);

  state_t     state_reg;
  logic [7:0] time_reg [NUM_FIELDS];
  logic       running_reg;
  logic       expired_reg;
  logic       done_reg;

  logic [7:0]            load_raw [NUM_FIELDS];
  logic [7:0]            load_val [NUM_FIELDS];
  logic [7:0]            dec_next [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] field_nonzero;
  logic [NUM_FIELDS-1:0] dec_field_zero;
  logic [NUM_FIELDS:0]   lower_zero;
  logic                  time_nonzero;
  logic                  dec_zero;
  logic                  prescale_en;
  logic                  tick;

  assign load_raw[FIELD_SEC] = bus.load_s;
  assign load_raw[FIELD_MIN] = bus.load_m;
  assign load_raw[FIELD_HR]  = bus.load_h;

  // Borrow chain: a field takes part in a decrement only when every less
  // significant field is already zero.
  always_comb begin
    lower_zero    = '0;
    lower_zero[0] = 1'b1;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      lower_zero[i+1] = lower_zero[i] && !field_nonzero[i];
    end
  end

  // Per-field clamp on load and next value on decrement. A zero field that
  // must borrow reloads to its maximum; because the timer only counts while
  // the total is nonzero, some higher field always absorbs the borrow.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    assign load_val[gi]       = clamp_field(load_raw[gi], field_max(gi));
    assign field_nonzero[gi]  = (time_reg[gi] != 8'd0);
    assign dec_next[gi]       = !lower_zero[gi]   ? time_reg[gi] :
                                field_nonzero[gi] ? time_reg[gi] - 8'd1 :
                                                    field_max(gi);
    assign dec_field_zero[gi] = (dec_next[gi] == 8'd0);
  end

  assign time_nonzero = |field_nonzero;
  assign dec_zero     = &dec_field_zero;

  // The prescaler only advances in RUN; a pause leaves its count intact.
  assign prescale_en = (state_reg == ST_RUN);

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .enable   (prescale_en),
    .clear    (bus.load),
    .tick     (tick)
  );

  // Control FSM with registered status flags and the remaining-time fields
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      running_reg <= 1'b0;
      expired_reg <= 1'b0;
      done_reg    <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        time_reg[i] <= 8'd0;
      end
    end else begin
      done_reg <= 1'b0;
      if (bus.load) begin
        // load overrides any start/pause in the same cycle
        state_reg   <= ST_IDLE;
        running_reg <= 1'b0;
        expired_reg <= 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
          time_reg[i] <= load_val[i];
        end
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // starting from 00:00:00 would expire with no countdown
            if (bus.start && time_nonzero) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
          ST_RUN: begin
            if (tick) begin
              for (int i = 0; i < NUM_FIELDS; i++) begin
                time_reg[i] <= dec_next[i];
              end
              if (dec_zero) begin
                state_reg   <= ST_EXPIRED;
                running_reg <= 1'b0;
                expired_reg <= 1'b1;
                done_reg    <= 1'b1;
              end else if (bus.pause) begin
                state_reg   <= ST_PAUSED;
                running_reg <= 1'b0;
              end
            end else if (bus.pause) begin
              state_reg   <= ST_PAUSED;
              running_reg <= 1'b0;
            end
          end
          ST_PAUSED: begin
            if (bus.start) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
          default: begin
            // EXPIRED holds 00:00:00 until the next load
          end
        endcase
      end
    end
  end

  assign bus.seconds = time_reg[FIELD_SEC];
  assign bus.minutes = time_reg[FIELD_MIN];
  assign bus.hours   = time_reg[FIELD_HR];
  assign bus.running = running_reg;
  assign bus.expired = expired_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with a short prescale period.
// The reference model keeps the remaining time as a plain total of seconds
// and a cycle counter within the current second.
module tb_countdown_timer;

  localparam int T = 4;

  localparam int MD_IDLE = 0;
  localparam int MD_RUN  = 1;
  localparam int MD_PAUS = 2;
  localparam int MD_EXP  = 3;

  logic CLOCK_50 = 1'b0;
  logic resetn;

  countdown_timer_if bus();

  countdown_timer #(
    .TICKS_PER_SEC (T)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_total;
  int m_phase;
  int m_mode;
  bit m_done;

  logic [26:0] dut_vec;
  assign dut_vec = {bus.hours, bus.minutes, bus.seconds,
                    bus.running, bus.expired, bus.done};

  function automatic void model_reset();
    m_total = 0;
    m_phase = 0;
    m_mode  = MD_IDLE;
    m_done  = 1'b0;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_step(input bit ld, input bit st, input bit ps,
                                     input int h, input int m, input int s);
    m_done = 1'b0;
    if (ld) begin
      m_total = imin(h, 99) * 3600 + imin(m, 59) * 60 + imin(s, 59);
      m_phase = 0;
      m_mode  = MD_IDLE;
    end else if (m_mode == MD_IDLE) begin
      if (st && m_total > 0) m_mode = MD_RUN;
    end else if (m_mode == MD_RUN) begin
      m_phase++;
      if (m_phase == T) begin
        m_phase = 0;
        m_total--;
        if (m_total == 0) begin
          m_mode = MD_EXP;
          m_done = 1'b1;
        end else if (ps) begin
          m_mode = MD_PAUS;
        end
      end else if (ps) begin
        m_mode = MD_PAUS;
      end
    end else if (m_mode == MD_PAUS) begin
      if (st) m_mode = MD_RUN;
    end
  endfunction

  function automatic logic [26:0] model_vec();
    logic [7:0] hh, mm, ss;
    hh = 8'(m_total / 3600);
    mm = 8'((m_total / 60) % 60);
    ss = 8'(m_total % 60);
    return {hh, mm, ss, (m_mode == MD_RUN), (m_mode == MD_EXP), m_done};
  endfunction

  // One clock cycle of stimulus; returns at the following falling edge.
  task automatic drive(input bit ld, input bit st, input bit ps,
                       input int h, input int m, input int s);
    bus.load   = ld;
    bus.start  = st;
    bus.pause  = ps;
    bus.load_h = 8'(h);
    bus.load_m = 8'(m);
    bus.load_s = 8'(s);
    @(posedge CLOCK_50);
    if (resetn) model_step(ld, st, ps, h & 255, m & 255, s & 255);
    else model_reset();
    @(negedge CLOCK_50);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL reset_state dut=%h model=%h", dut_vec, model_vec());
    end
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d dut=%h model=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_expire();
    drive(1, 0, 0, 0, 0, 3);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL expire cyc %0d dut=%h model=%h", i, dut_vec, model_vec());
      end
      if (i == 4) begin
        checks++;
        if (bus.seconds !== 8'd2) begin
          errors++;
          $display("FAIL expire_first_dec got %0d want 2", bus.seconds);
        end
      end
      if (i == 12) begin
        checks++;
        if ({bus.seconds, bus.done, bus.expired, bus.running} !== {8'd0, 3'b110}) begin
          errors++;
          $display("FAIL expire_done sec=%0d done=%b exp=%b run=%b want 0 1 1 0",
                   bus.seconds, bus.done, bus.expired, bus.running);
        end
      end
      if (i == 13) begin
        checks++;
        if (bus.done !== 1'b0) begin
          errors++;
          $display("FAIL done_width done=%b want 0", bus.done);
        end
      end
    end
  endtask

  task automatic test_borrow_clamp();
    drive(1, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL borrow cyc %0d dut=%h model=%h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if ({bus.hours, bus.minutes, bus.seconds} !== {8'd0, 8'd59, 8'd59}) begin
      errors++;
      $display("FAIL borrow_value got %0d:%0d:%0d want 0:59:59",
               bus.hours, bus.minutes, bus.seconds);
    end
    drive(1, 0, 0, 150, 75, 80);
    checks++;
    if ({bus.hours, bus.minutes, bus.seconds, bus.running} !== {8'd99, 8'd59, 8'd59, 1'b0}) begin
      errors++;
      $display("FAIL clamp got %0d:%0d:%0d run=%b want 99:59:59 run=0",
               bus.hours, bus.minutes, bus.seconds, bus.running);
    end
  endtask

  task automatic test_pause_resume();
    drive(1, 0, 0, 0, 0, 5);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, (i == 6), 0, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL pause_run cyc %0d dut=%h model=%h", i, dut_vec, model_vec());
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.seconds !== 8'd4 || bus.running !== 1'b0 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL pause_hold cyc %0d sec=%0d run=%b want 4 0", i, bus.seconds, bus.running);
      end
    end
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.seconds !== ((i == 2) ? 8'd3 : 8'd4) || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL resume cyc %0d sec=%0d want %0d", i, bus.seconds, (i == 2) ? 3 : 4);
      end
    end
  endtask

  task automatic test_zero_start();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.expired !== 1'b0 ||
          dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL zero_start cyc %0d run=%b done=%b exp=%b want 0 0 0",
                 i, bus.running, bus.done, bus.expired);
      end
    end
    drive(1, 1, 0, 0, 0, 5);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.running !== 1'b0 || bus.seconds !== 8'd5 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL load_start cyc %0d run=%b sec=%0d want 0 5", i, bus.running, bus.seconds);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 2, 10);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL pre_reset dut=%h model=%h", dut_vec, model_vec());
    end
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 27'd0) begin
      errors++;
      $display("FAIL async_reset dut=%h want 0", dut_vec);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.running !== 1'b0 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL start_after_reset cyc %0d dut=%h model=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_expired_hold();
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    checks++;
    if (dut_vec !== {24'd0, 3'b010} || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL expired_hold dut=%h want %h", dut_vec, {24'd0, 3'b010});
    end
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.done !== (i == 4) || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL reexpire cyc %0d done=%b dut=%h model=%h", i, bus.done, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    bit ld, st, ps;
    int h, m, s;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 5) == 0);
      ps = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) begin
        h = 0;
        m = 0;
        s = $urandom_range(0, 3);
      end else begin
        h = $urandom_range(0, 255);
        m = $urandom_range(0, 255);
        s = $urandom_range(0, 255);
      end
      drive(ld, st, ps, h, m, s);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL random cyc %0d ld=%b st=%b ps=%b dut=%h model=%h",
                 i, ld, st, ps, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    resetn     = 1'b0;
    bus.load   = 1'b0;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.load_h = 8'd0;
    bus.load_m = 8'd0;
    bus.load_s = 8'd0;
    model_reset();
    test_reset();
    test_expire();
    test_borrow_clamp();
    test_pause_resume();
    test_zero_start();
    test_async_reset();
    test_expired_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50000000, number of CLOCK_50 cycles per decrement (minimum 2).
REQ-002 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 load  input  1  single-cycle pulse; captures load_h/load_m/load_s as the new remaining time.
REQ-005 load_h, load_m, load_s  input  8 each  binary hours/minutes/seconds to load.
REQ-006 start  input  1  single-cycle pulse; begins or resumes the countdown.
REQ-007 pause  input  1  single-cycle pulse; freezes a running countdown.
REQ-008 hours, minutes, seconds  output  8 each  registered binary remaining time, hex-display compatible.
REQ-009 running  output  1  high while state is RUN.
REQ-010 expired  output  1  high while state is EXPIRED.
REQ-011 done  output  1  one-cycle pulse when the count reaches 00:00:00.

Function
REQ-012 The block SHALL implement states IDLE, RUN, PAUSED, EXPIRED.
REQ-013 load in any state SHALL capture clamped values (hours max 99, minutes max 59, seconds max 59), clear the prescaler, and enter IDLE the next cycle.
REQ-014 load SHALL take priority over start and pause in the same cycle.
REQ-015 start in IDLE SHALL enter RUN only if the held time is nonzero; with 00:00:00 it SHALL be ignored.
REQ-016 In RUN the prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap to 0, issuing one decrement on the wrap cycle.
REQ-017 Decrement: seconds>0 -> seconds-1; else minutes>0 -> seconds=59, minutes-1; else hours>0 -> seconds=59, minutes=59, hours-1.
REQ-018 The decrement producing 00:00:00 SHALL move to EXPIRED; done SHALL be high for exactly the first cycle the outputs show 00:00:00.
REQ-019 pause in RUN SHALL enter PAUSED with prescaler and time held; pause in other states SHALL be ignored.
REQ-020 pause and a prescaler wrap in the same RUN cycle: the decrement SHALL still occur, then PAUSED.
REQ-021 start in PAUSED SHALL resume RUN from the held prescaler value; start in RUN or EXPIRED SHALL be ignored.
REQ-022 EXPIRED SHALL hold 00:00:00 and expired=1 until load.
REQ-023 From first decrement of a full-second load, each decrement SHALL occur exactly TICKS_PER_SEC cycles after the previous.

Reset
REQ-024 resetn low SHALL immediately force state IDLE, prescaler 0, hours/minutes/seconds 0, running/expired/done 0, regardless of clock.
REQ-025 Reset mid-countdown SHALL discard remaining time; a start after release SHALL be ignored until a nonzero load.

Structure
REQ-026 A shared package SHALL hold the state enumeration and constants MAX_SECONDS=59, MAX_MINUTES=59, MAX_HOURS=99.
REQ-027 The prescaler SHALL be a sub-module sec_tick_gen (enable, clear, one-cycle tick output); its width SHALL be derived from TICKS_PER_SEC.

Verification (TICKS_PER_SEC=4)
REQ-028 Load 00:00:03, start -> seconds 2,1,0 at 4-cycle spacing; done one cycle with 0; expired=1, running=0.
REQ-029 Load 01:00:00, start -> after one tick shows 00:59:59; load 150:75:80 -> reads 99:59:59.
REQ-030 Run 00:00:05, pause after 6 cycles, wait 20 cycles, start -> value frozen at 4 while paused; next decrement 2 cycles after resume.
REQ-031 Load 00:00:00, start -> stays IDLE, running=0, no done; load and start same cycle -> IDLE.
REQ-032 resetn low asynchronously mid-RUN at 00:02:10 -> outputs 0 before next clock edge; start after release ignored.
REQ-033 In EXPIRED apply start and pause -> no change; load 00:00:01, start -> expires after 4 cycles with done pulse.
